// File: rtl/fb_bank_mapper.sv
// N-buffer framebuffer address mapper with vblank-synchronised buffer flips.
// Optional saturating flip/drop counters are enabled by defining FB_SWAP_STATS_EN.
module fb_bank_mapper #(
  parameter int ADDR_W     = 19,
  parameter int FRAME_SIZE = 307200,
  parameter int NUM_BUF    = 2,
  parameter int MEM_ADDR_W = 21
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     draw_addr,
  input  logic                  draw_we,
  input  logic [ADDR_W-1:0]     vga_addr,
  input  logic                  frame_start,
  input  logic                  swap_req,
  output logic [MEM_ADDR_W-1:0] mem_addr_draw,
  output logic                  mem_we_draw,
  output logic [MEM_ADDR_W-1:0] mem_addr_disp,
  output logic [1:0]            draw_buf,
  output logic [1:0]            disp_buf,
  output logic                  swap_busy,
  output logic                  swap_done,
  output logic                  swap_overrun,
  output logic                  draw_oob
`ifdef FB_SWAP_STATS_EN
  ,
  output logic [15:0]           flip_count,
  output logic [15:0]           drop_count
`endif
);

  typedef enum logic {S_IDLE, S_PENDING} state_t;

  localparam logic [MEM_ADDR_W-1:0] FS_M = MEM_ADDR_W'(FRAME_SIZE);
  localparam logic [ADDR_W:0]       FS_A = (ADDR_W + 1)'(FRAME_SIZE);

  state_t                  state_q, state_d;
  logic [1:0]              draw_q, draw_d;
  logic [1:0]              disp_q, disp_d;
  logic [1:0]              ready_idx_q, ready_idx_d;
  logic                    ready_valid_q, ready_valid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    overrun_q, overrun_d;
  logic [MEM_ADDR_W-1:0]   addr_draw_q, addr_disp_q;
  logic                    we_q, oob_q;
  logic                    oob_d;
  logic [1:0]              free_idx;
  logic                    free_found;

  function automatic logic [MEM_ADDR_W-1:0] map_addr(input logic [1:0]        idx,
                                                      input logic [ADDR_W-1:0] a);
    return MEM_ADDR_W'(idx) * FS_M + MEM_ADDR_W'(a);
  endfunction

  assign oob_d = ({1'b0, draw_addr} >= FS_A);

  // Lowest buffer index held by neither the display nor the renderer.
  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int unsigned i = 0; i < NUM_BUF; i++) begin
      if (!free_found && 2'(i) != draw_q && 2'(i) != disp_q) begin
        free_idx   = 2'(i);
        free_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    draw_d        = draw_q;
    disp_d        = disp_q;
    ready_idx_d   = ready_idx_q;
    ready_valid_d = ready_valid_q;
    done_d        = 1'b0;
    overrun_d     = 1'b0;
    busy_d        = 1'b0;
    if (NUM_BUF == 2) begin
      case (state_q)
        S_IDLE: begin
          if (swap_req && frame_start) begin
            draw_d = disp_q;
            disp_d = draw_q;
            done_d = 1'b1;
          end else if (swap_req) begin
            state_d = S_PENDING;
          end
        end
        default: begin
          if (swap_req) overrun_d = 1'b1;
          if (frame_start) begin
            draw_d  = disp_q;
            disp_d  = draw_q;
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      endcase
      busy_d = (state_d == S_PENDING);
    end else begin
      // Submission is resolved first so a same-cycle vblank displays the new frame.
      if (swap_req) begin
        ready_idx_d = draw_q;
        if (ready_valid_q) begin
          draw_d    = ready_idx_q;
          overrun_d = 1'b1;
        end else begin
          draw_d        = free_idx;
          ready_valid_d = 1'b1;
        end
      end
      if (frame_start && ready_valid_d) begin
        disp_d        = ready_idx_d;
        ready_valid_d = 1'b0;
        done_d        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      draw_q        <= 2'd1;
      disp_q        <= '0;
      ready_idx_q   <= '0;
      ready_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      overrun_q     <= 1'b0;
      addr_draw_q   <= '0;
      addr_disp_q   <= '0;
      we_q          <= 1'b0;
      oob_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      draw_q        <= draw_d;
      disp_q        <= disp_d;
      ready_idx_q   <= ready_idx_d;
      ready_valid_q <= ready_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      overrun_q     <= overrun_d;
      addr_draw_q   <= map_addr(draw_q, draw_addr);
      addr_disp_q   <= map_addr(disp_q, vga_addr);
      we_q          <= draw_we & ~oob_d;
      oob_q         <= oob_d;
    end
  end

  assign mem_addr_draw = addr_draw_q;
  assign mem_addr_disp = addr_disp_q;
  assign mem_we_draw   = we_q;
  assign draw_oob      = oob_q;
  assign draw_buf      = draw_q;
  assign disp_buf      = disp_q;
  assign swap_busy     = busy_q;
  assign swap_done     = done_q;
  assign swap_overrun  = overrun_q;

`ifdef FB_SWAP_STATS_EN
  logic [15:0] flip_q, drop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flip_q <= '0;
      drop_q <= '0;
    end else begin
      if (done_d && flip_q != '1)    flip_q <= flip_q + 16'd1;
      if (overrun_d && drop_q != '1) drop_q <= drop_q + 16'd1;
    end
  end

  assign flip_count = flip_q;
  assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_fb_bank_mapper.sv
// Directed bench for fb_bank_mapper: double-buffer (NUM_BUF=2) and triple-buffer
// (NUM_BUF=3) instances sharing clock, reset and address inputs.
module tb_fb_bank_mapper;
  localparam int FS = 307200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [18:0] draw_addr, vga_addr;
  logic        draw_we;
  logic        frame_start, swap_req;
  logic        frame_start3, swap_req3;

  logic [20:0] mad2, mdp2, mad3, mdp3;
  logic        we2, we3, busy2, busy3, done2, done3, ovr2, ovr3, oob2, oob3;
  logic [1:0]  db2, dp2, db3, dp3;
`ifdef FB_SWAP_STATS_EN
  logic [15:0] fc2, dc2, fc3, dc3;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fb_bank_mapper #(.ADDR_W(19), .FRAME_SIZE(FS), .NUM_BUF(2), .MEM_ADDR_W(21)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .draw_addr(draw_addr), .draw_we(draw_we),
    .vga_addr(vga_addr), .frame_start(frame_start), .swap_req(swap_req),
    .mem_addr_draw(mad2), .mem_we_draw(we2), .mem_addr_disp(mdp2),
    .draw_buf(db2), .disp_buf(dp2), .swap_busy(busy2), .swap_done(done2),
    .swap_overrun(ovr2), .draw_oob(oob2)
`ifdef FB_SWAP_STATS_EN
    , .flip_count(fc2), .drop_count(dc2)
`endif
  );

  fb_bank_mapper #(.ADDR_W(19), .FRAME_SIZE(FS), .NUM_BUF(3), .MEM_ADDR_W(21)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .draw_addr(draw_addr), .draw_we(draw_we),
    .vga_addr(vga_addr), .frame_start(frame_start3), .swap_req(swap_req3),
    .mem_addr_draw(mad3), .mem_we_draw(we3), .mem_addr_disp(mdp3),
    .draw_buf(db3), .disp_buf(dp3), .swap_busy(busy3), .swap_done(done3),
    .swap_overrun(ovr3), .draw_oob(oob3)
`ifdef FB_SWAP_STATS_EN
    , .flip_count(fc3), .drop_count(dc3)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; draw_addr = '0; vga_addr = '0; draw_we = 1'b0;
    frame_start = 1'b0; swap_req = 1'b0; frame_start3 = 1'b0; swap_req3 = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;

    // Reset state and basic mapping
    check_eq("rst_draw_buf", 32'(db2), 1);
    check_eq("rst_disp_buf", 32'(dp2), 0);
    check_eq("rst_busy", 32'(busy2), 0);
    draw_addr = 19'd5; vga_addr = 19'd7;
    cyc();
    check_eq("map_draw", 32'(mad2), 307205);
    check_eq("map_disp", 32'(mdp2), 7);
    check_eq("map_draw3", 32'(mad3), 307205);

    // Double-buffer flip with a long wait for vblank
    swap_req = 1'b1;
    cyc(); swap_req = 1'b0;
    check_eq("busy_after_req", 32'(busy2), 1);
    check_eq("busy3_tied", 32'(busy3), 0);
    for (int i = 0; i < 38; i++) begin
      cyc();
      check_eq("busy_hold", 32'(busy2), 1);
    end
    check_eq("no_early_flip", 32'(db2), 1);
    frame_start = 1'b1;
    cyc(); frame_start = 1'b0;
    check_eq("flip_done", 32'(done2), 1);
    check_eq("flip_busy_clr", 32'(busy2), 0);
    check_eq("flip_draw_buf", 32'(db2), 0);
    check_eq("flip_disp_buf", 32'(dp2), 1);
    vga_addr = 19'd0;
    cyc();
    check_eq("done_pulse_end", 32'(done2), 0);
    check_eq("map_disp_buf1", 32'(mdp2), 307200);
    check_eq("map_draw_buf0", 32'(mad2), 5);

    // Overrun while pending: single flip only (draw=0, disp=1 -> draw=1, disp=0)
    swap_req = 1'b1;
    cyc(); swap_req = 1'b1;
    check_eq("ovr_busy", 32'(busy2), 1);
    cyc(); swap_req = 1'b0;
    check_eq("ovr_pulse", 32'(ovr2), 1);
    check_eq("ovr_still_busy", 32'(busy2), 1);
    cyc();
    check_eq("ovr_pulse_end", 32'(ovr2), 0);
    frame_start = 1'b1;
    cyc(); frame_start = 1'b0;
    check_eq("ovr_flip_done", 32'(done2), 1);
    check_eq("ovr_flip_draw", 32'(db2), 1);
    check_eq("ovr_flip_disp", 32'(dp2), 0);
    frame_start = 1'b1;
    cyc(); frame_start = 1'b0;
    check_eq("idle_vblank_nodone", 32'(done2), 0);
    check_eq("idle_vblank_disp", 32'(dp2), 0);

    // Simultaneous request and vblank: immediate flip, busy never asserts
    swap_req = 1'b1; frame_start = 1'b1;
    cyc(); swap_req = 1'b0; frame_start = 1'b0;
    check_eq("sim_done", 32'(done2), 1);
    check_eq("sim_busy", 32'(busy2), 0);
    check_eq("sim_draw", 32'(db2), 0);
    check_eq("sim_disp", 32'(dp2), 1);
    swap_req = 1'b1; frame_start = 1'b1;
    cyc(); swap_req = 1'b0; frame_start = 1'b0;
    check_eq("sim2_draw", 32'(db2), 1);

    // Bounds check (draw_buf=1, disp_buf=0)
    draw_we = 1'b1; draw_addr = 19'd307200; vga_addr = 19'd307300;
    cyc();
    check_eq("oob_we", 32'(we2), 0);
    check_eq("oob_flag", 32'(oob2), 1);
    check_eq("disp_oob_maps", 32'(mdp2), 307300);
    draw_addr = 19'd307199;
    cyc();
    check_eq("inb_we", 32'(we2), 1);
    check_eq("inb_flag", 32'(oob2), 0);
    check_eq("inb_addr", 32'(mad2), 614399);
    draw_we = 1'b0;
    cyc();
    check_eq("we_low", 32'(we2), 0);

    // Triple buffering (dut3 still draw=1, disp=0, no ready frame)
    swap_req3 = 1'b1;
    cyc(); swap_req3 = 1'b1;
    check_eq("tri_draw_free", 32'(db3), 2);
    check_eq("tri_no_ovr", 32'(ovr3), 0);
    check_eq("tri_no_done", 32'(done3), 0);
    cyc(); swap_req3 = 1'b0;
    check_eq("tri_ovr", 32'(ovr3), 1);
    check_eq("tri_draw_old_ready", 32'(db3), 1);
    frame_start3 = 1'b1;
    cyc(); frame_start3 = 1'b0;
    check_eq("tri_done", 32'(done3), 1);
    check_eq("tri_disp", 32'(dp3), 2);
    check_eq("tri_draw_keep", 32'(db3), 1);
    check_eq("tri_busy", 32'(busy3), 0);
    frame_start3 = 1'b1;
    cyc(); frame_start3 = 1'b0;
    check_eq("tri_vblank_empty", 32'(done3), 0);
    check_eq("tri_vblank_disp", 32'(dp3), 2);
    swap_req3 = 1'b1; frame_start3 = 1'b1;
    cyc(); swap_req3 = 1'b0; frame_start3 = 1'b0;
    check_eq("tri_sim_done", 32'(done3), 1);
    check_eq("tri_sim_no_ovr", 32'(ovr3), 0);
    check_eq("tri_sim_draw", 32'(db3), 0);
    check_eq("tri_sim_disp", 32'(dp3), 1);
    swap_req3 = 1'b1;
    cyc(); swap_req3 = 1'b1; frame_start3 = 1'b1;
    check_eq("tri_pre_draw", 32'(db3), 2);
    cyc(); swap_req3 = 1'b0; frame_start3 = 1'b0;
    check_eq("tri_sim2_done", 32'(done3), 1);
    check_eq("tri_sim2_ovr", 32'(ovr3), 1);
    check_eq("tri_sim2_draw", 32'(db3), 0);
    check_eq("tri_sim2_disp", 32'(dp3), 2);
    vga_addr = 19'd3;
    cyc();
    check_eq("tri_map_disp", 32'(mdp3), 614403);

`ifdef FB_SWAP_STATS_EN
    check_eq("flip_count2", 32'(fc2), 4);
    check_eq("drop_count2", 32'(dc2), 1);
    check_eq("flip_count3", 32'(fc3), 3);
    check_eq("drop_count3", 32'(dc3), 2);
`endif

    // Asynchronous reset mid-swap: pending flip is lost
    swap_req = 1'b1;
    cyc(); swap_req = 1'b0;
    check_eq("pre_rst_busy", 32'(busy2), 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_busy", 32'(busy2), 0);
    check_eq("arst_draw_buf", 32'(db2), 1);
    check_eq("arst_disp_buf", 32'(dp2), 0);
    check_eq("arst_addr_disp", 32'(mdp2), 0);
    check_eq("arst_draw_buf3", 32'(db3), 1);
`ifdef FB_SWAP_STATS_EN
    check_eq("arst_flip_count", 32'(fc2), 0);
`endif
    cyc(); rst_n = 1'b1;
    frame_start = 1'b1;
    cyc(); frame_start = 1'b0;
    check_eq("lost_flip_done", 32'(done2), 0);
    check_eq("lost_flip_draw", 32'(db2), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fb_bank_mapper.md
Name: fb_bank_mapper

Overview:
- Parametrised N-buffer framebuffer address mapper with vblank-synchronised buffer flipping.
- Maps the renderer (draw) pixel address and the VGA scan (display) pixel address onto one linear memory.
- Each buffer occupies FRAME_SIZE words. Buffer i starts at i*FRAME_SIZE.
- Supports double buffering (NUM_BUF=2) and triple/quad buffering (NUM_BUF=3..4) with a swap request/done handshake. Sits between the line-drawing pipeline, the VGA timing generator and the frame memory.

Parameters:
- ADDR_W, 19, pixel address width per buffer.
- FRAME_SIZE, 307200, words per buffer (640x480).
- NUM_BUF, 2, number of buffers. Legal values 2..4.
- MEM_ADDR_W, 21, memory address width. Must satisfy NUM_BUF*FRAME_SIZE <= 2^MEM_ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- draw_addr  in  ADDR_W  renderer pixel address.
- draw_we  in  1  renderer write strobe.
- vga_addr  in  ADDR_W  display scan pixel address.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- swap_req  in  1  one-cycle pulse: renderer finished current frame.
- mem_addr_draw  out  MEM_ADDR_W  registered memory address, draw side.
- mem_we_draw  out  1  registered write strobe, gated by bounds check.
- mem_addr_disp  out  MEM_ADDR_W  registered memory address, display side.
- draw_buf  out  2  current draw buffer index.
- disp_buf  out  2  current display buffer index.
- swap_busy  out  1  swap pending; renderer must not draw.
- swap_done  out  1  one-cycle pulse: flip committed.
- swap_overrun  out  1  one-cycle pulse: request dropped or older ready frame discarded.
- draw_oob  out  1  registered: last draw_addr >= FRAME_SIZE.

Behaviour:
- Reset (async, rst_n=0): disp_buf=0, draw_buf=1, ready_valid=0, pending=0. All outputs are 0 except draw_buf=1.
- Address path, latency 1:
  - mem_addr_draw <= draw_buf*FRAME_SIZE + draw_addr.
  - mem_addr_disp <= disp_buf*FRAME_SIZE + vga_addr.
  - Both use the indices valid before the same edge's update.
  - Sum is zero-extended to MEM_ADDR_W. No wrap is allowed.
- Bounds check:
  - draw_oob <= (draw_addr >= FRAME_SIZE).
  - mem_we_draw <= draw_we & ~that comparison.
  - An out-of-range display address still maps; it is not flagged.
- Double buffer mode (NUM_BUF=2), states IDLE and PENDING:
  - IDLE + swap_req -> PENDING, swap_busy=1 from the next cycle.
  - PENDING + frame_start -> exchange draw_buf/disp_buf, return to IDLE, swap_done=1 for one cycle, swap_busy=0.
  - swap_req and frame_start in the same cycle while IDLE: flip immediately, swap_done next cycle, swap_busy never asserts.
  - swap_req while PENDING: ignored, swap_overrun pulse.
  - frame_start in IDLE: no change.
- Multi-buffer mode (NUM_BUF>=3): swap_busy is tied 0.
  - swap_req with ready_valid=0:
    - ready_idx <= draw_buf, ready_valid <= 1.
    - draw_buf <= lowest index that is neither disp_buf nor draw_buf.
  - swap_req with ready_valid=1:
    - ready_idx <= draw_buf, draw_buf <= old ready_idx.
    - swap_overrun pulse (older frame discarded).
  - frame_start with ready_valid=1: disp_buf <= ready_idx, ready_valid <= 0, swap_done pulse. The freed buffer becomes free.
  - swap_req and frame_start in the same cycle: swap_req is applied first. The just-submitted buffer goes to display that edge, ready_valid ends 0, swap_done pulses. If a ready frame existed, it is discarded with swap_overrun.
- Invariant: draw_buf != disp_buf, and ready_idx differs from both whenever ready_valid=1.
- Reset mid-swap: everything returns to the reset state and the pending flip is lost.

Optional Feature:
- Macro FB_SWAP_STATS_EN.
- When defined:
  - Adds outputs flip_count[15:0] and drop_count[15:0], both reset to 0.
  - flip_count increments on each swap_done. drop_count increments on each swap_overrun.
  - Both saturate at 16'hFFFF.
- When undefined: ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-cycle -> outputs 0 immediately, draw_buf=1, disp_buf=0. Then draw_addr=5, vga_addr=7 -> next cycle mem_addr_draw=307205, mem_addr_disp=7.
- NUM_BUF=2 flip: swap_req at cycle 10, frame_start at cycle 50 -> swap_busy=1 for cycles 11..50, swap_done at 51, draw_buf=0, disp_buf=1. vga_addr=0 -> mem_addr_disp=307200.
- NUM_BUF=2 overrun and simultaneous: second swap_req while PENDING -> swap_overrun pulse, single flip only. swap_req and frame_start in the same cycle -> immediate flip, swap_busy stays 0.
- NUM_BUF=3 triple: from reset, swap_req -> draw_buf=2, ready=1. Second swap_req before frame_start -> swap_overrun, draw_buf=1, ready=2. frame_start -> disp_buf=2, swap_done.
- Bounds: draw_we=1, draw_addr=307200 -> mem_we_draw=0, draw_oob=1. draw_addr=307199 -> mem_we_draw=1, draw_oob=0, mem_addr_draw=614399.
- With FB_SWAP_STATS_EN: 3 flips and 2 overruns -> flip_count=3, drop_count=2. Preload near 16'hFFFF -> counters saturate, no wrap.
